uart_rx_oversample: RTL

Oversampling UART receive front end. It converts the asynchronous rx pin into validated bytes and writes them into the Rx FIFO of the UART bus wrapper. It replaces the single-sample receive path with these features:
- 2-flop synchroniser
- 3-sample majority vote per bit
- false-start rejection
- framing, break and overrun detection

---
 rtl/uart_rx_oversample.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: synchronise rx, vote 3 mid-bit samples, emit one done/frame_err/break_det/overrun pulse per frame.
// Latency SYNC_STAGES+1+r*(OVERSAMPLE*(DATA_BITS+1)+OVERSAMPLE/2+2) clk from rx fall to done; no backpressure, fifo_full turns a good frame into overrun.
module uart_rx_oversample #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [15:0]          rate,
    input  logic                 rx,
    input  logic                 clear,
    input  logic                 fifo_full,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 done,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] VOTE_AT  = CNT_W'(OVERSAMPLE / 2 + 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] syncReg;
    logic                   rxPrev;
    logic [2:0]             samples;
    logic [15:0]            rateQ;
    logic [15:0]            tickCnt;
    logic [CNT_W-1:0]       sampleCnt;
    logic [IDX_W-1:0]       bitIdx;
    logic [DATA_BITS-1:0]   shiftReg;
    logic                   waitHigh;

    logic                   rxS;
    logic [15:0]            rateEff;
    logic                   startEdge;
    logic                   tick;
    logic [CNT_W-1:0]       nextCnt;
    logic                   atWrap;
    logic                   atVote;
    logic                   voteBit;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    always_comb begin
        rxS       = syncReg[SYNC_STAGES-1];
        rateEff   = (rate == 16'd0) ? 16'd1 : rate;
        startEdge = (state == IDLE) && !waitHigh && rxPrev && !rxS;
        tick      = (state != IDLE) && (tickCnt == rateQ - 16'd1);
        nextCnt   = (sampleCnt == CNT_LAST) ? '0 : sampleCnt + CNT_W'(1);
        atWrap    = tick && (sampleCnt == CNT_LAST);
        atVote    = tick && (nextCnt == VOTE_AT);
        voteBit   = majority3(samples);
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state     <= IDLE;
            syncReg   <= '1;
            rxPrev    <= 1'b1;
            samples   <= 3'b111;
            tickCnt   <= '0;
            sampleCnt <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            waitHigh  <= 1'b0;
            data_out  <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
            break_det <= 1'b0;
            overrun   <= 1'b0;
            // clear aborts a frame but keeps the last latched rate
            if (reset) begin
                rateQ <= 16'd1;
            end
        end else begin
            syncReg   <= {syncReg[SYNC_STAGES-2:0], rx};
            rxPrev    <= rxS;
            done      <= 1'b0;
            frame_err <= 1'b0;
            break_det <= 1'b0;
            overrun   <= 1'b0;

            if (state == IDLE || startEdge || tick) begin
                tickCnt <= '0;
            end else begin
                tickCnt <= tickCnt + 16'd1;
            end

            if (state != IDLE && tick) begin
                sampleCnt <= nextCnt;
                if (nextCnt == SAMP_A) samples[0] <= rxS;
                if (nextCnt == SAMP_B) samples[1] <= rxS;
                if (nextCnt == SAMP_C) samples[2] <= rxS;
            end

            case (state)
                IDLE: begin
                    if (rxS) begin
                        waitHigh <= 1'b0;
                    end
                    if (startEdge) begin
                        state     <= START;
                        sampleCnt <= '0;
                        bitIdx    <= '0;
                        rateQ     <= rateEff;
                    end
                end
                START: begin
                    if (atVote && voteBit) begin
                        state <= IDLE;
                    end else if (atWrap) begin
                        state  <= DATA;
                        bitIdx <= '0;
                    end
                end
                DATA: begin
                    // shifting in at the MSB leaves the first bit in the LSB after DATA_BITS votes
                    if (atVote) begin
                        shiftReg <= {voteBit, shiftReg[DATA_BITS-1:1]};
                    end
                    if (atWrap) begin
                        if (bitIdx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bitIdx <= bitIdx + IDX_W'(1);
                        end
                    end
                end
                STOP: begin
                    // leave at mid-stop so a back-to-back start bit is not missed
                    if (atVote) begin
                        state <= IDLE;
                        if (voteBit) begin
                            if (fifo_full) begin
                                overrun <= 1'b1;
                            end else begin
                                data_out <= shiftReg;
                                done     <= 1'b1;
                            end
                        end else begin
                            waitHigh <= 1'b1;
                            if (shiftReg == '0) begin
                                break_det <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
